// File: rtl/exp4_unidade_controle_pkg.sv
// State codes for the game control unit, shared by design and bench.
package exp4_unidade_controle_pkg;

  localparam logic [3:0] INICIAL       = 4'h0;
  localparam logic [3:0] PREPARACAO    = 4'h1;
  localparam logic [3:0] ESPERA_JOGADA = 4'h2;
  localparam logic [3:0] REGISTRA      = 4'h4;
  localparam logic [3:0] COMPARACAO    = 4'h5;
  localparam logic [3:0] PROXIMO       = 4'h6;
  localparam logic [3:0] FIM_ACERTO    = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT   = 4'hD;
  localparam logic [3:0] FIM_ERRO      = 4'hE;

endpackage

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the memory game: sequences the datapath
// through each jogada and reports the final verdict.
module exp4_unidade_controle
  import exp4_unidade_controle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  input  logic       fim_4_jogadas,
  input  logic       timeout,
  input  logic       db_modo,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registrarR,
  output logic       zera_s_timeout,
  output logic       registra_modo,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       perdeu_timeout,
  output logic [3:0] db_estado
);

  logic [3:0] estado;
  logic [3:0] prox;
  logic       ultima;

  assign ultima = db_modo ? fim_4_jogadas : fimC;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:       prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    prox = ESPERA_JOGADA;
      // a finished jogada takes priority over a simultaneous timeout
      ESPERA_JOGADA: begin
        if (jogada_feita) prox = REGISTRA;
        else if (timeout) prox = FIM_TIMEOUT;
      end
      REGISTRA:      prox = COMPARACAO;
      COMPARACAO: begin
        if (!igual)      prox = FIM_ERRO;
        else if (ultima) prox = FIM_ACERTO;
        else             prox = PROXIMO;
      end
      PROXIMO:       prox = ESPERA_JOGADA;
      FIM_ACERTO,
      FIM_TIMEOUT,
      FIM_ERRO:      prox = iniciar ? PREPARACAO : estado;
      default:       prox = INICIAL;
    endcase
  end

  always_comb begin
    zeraC          = 1'b0;
    contaC         = 1'b0;
    zeraR          = 1'b0;
    registrarR     = 1'b0;
    zera_s_timeout = 1'b0;
    registra_modo  = 1'b0;
    pronto         = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    perdeu_timeout = 1'b0;
    case (estado)
      PREPARACAO: begin
        zeraC          = 1'b1;
        zeraR          = 1'b1;
        zera_s_timeout = 1'b1;
        registra_modo  = 1'b1;
      end
      REGISTRA: begin
        registrarR     = 1'b1;
        zera_s_timeout = 1'b1;
      end
      PROXIMO:     contaC = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto         = 1'b1;
        perdeu_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Scoreboard bench: stimulus queues expected state/outputs, monitor checks.
module tb_exp4_unidade_controle;
  import exp4_unidade_controle_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0;
  logic jogada_feita = 1'b0;
  logic igual = 1'b0;
  logic fimC = 1'b0;
  logic fim_4_jogadas = 1'b0;
  logic timeout = 1'b0;
  logic db_modo = 1'b0;
  logic zeraC, contaC, zeraR, registrarR, zera_s_timeout, registra_modo;
  logic pronto, acertou, errou, perdeu_timeout;
  logic [3:0] db_estado;

  exp4_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .igual(igual), .fimC(fimC),
    .fim_4_jogadas(fim_4_jogadas), .timeout(timeout), .db_modo(db_modo),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registrarR(registrarR), .zera_s_timeout(zera_s_timeout),
    .registra_modo(registra_modo), .pronto(pronto), .acertou(acertou),
    .errou(errou), .perdeu_timeout(perdeu_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [3:0] st;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int total = 0;
  int bad = 0;
  int nconta = 0;

  wire [9:0] outs = {zeraC, contaC, zeraR, registrarR, zera_s_timeout,
                     registra_modo, pronto, acertou, errou, perdeu_timeout};

  // expected Moore outputs for each state code
  function automatic logic [9:0] exp_outs(input logic [3:0] s);
    case (s)
      4'h1:    return 10'b1010110000;
      4'h4:    return 10'b0001100000;
      4'h6:    return 10'b0100000000;
      4'hA:    return 10'b0000001100;
      4'hE:    return 10'b0000001010;
      4'hD:    return 10'b0000001001;
      default: return 10'b0000000000;
    endcase
  endfunction

  task automatic check(input string n, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", n, got, want);
    end
  endtask

  always @(posedge clock) if (contaC) nconta <= nconta + 1;

  initial begin
    exp_t e;
    forever begin
      @(posedge clock or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".st"}, int'(db_estado), int'(e.st));
        check({e.name, ".outs"}, int'(outs), int'(exp_outs(e.st)));
      end
    end
  end

  task automatic step(input string n, input logic [3:0] st);
    q.push_back('{n, st});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic jog(input string n, input logic ig, input logic ult);
    jogada_feita = 1'b1;
    step({n, "_reg"}, REGISTRA);
    jogada_feita = 1'b0;
    igual = ig;
    fimC = db_modo ? 1'b0 : ult;
    fim_4_jogadas = db_modo ? ult : 1'b0;
    step({n, "_cmp"}, COMPARACAO);
    step({n, "_res"}, !ig ? FIM_ERRO : (ult ? FIM_ACERTO : PROXIMO));
    igual = 1'b0;
    fimC = 1'b0;
    fim_4_jogadas = 1'b0;
    if (ig && !ult) step({n, "_back"}, ESPERA_JOGADA);
  endtask

  task automatic start(input string n);
    iniciar = 1'b1;
    step({n, "_prep"}, PREPARACAO);
    iniciar = 1'b0;
    step({n, "_wait"}, ESPERA_JOGADA);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) @(negedge clock);
    q.push_back('{"reset_hold", INICIAL});
    ->chk_ev;
    @(negedge clock);
    reset = 1'b1;
    step("idle_no_start", INICIAL);
    start("g1");
    iniciar = 1'b1;
    step("ignore_iniciar", ESPERA_JOGADA);
    iniciar = 1'b0;
    step("hold_wait", ESPERA_JOGADA);

    db_modo = 1'b1;
    base = nconta;
    for (int i = 1; i <= 4; i++) jog("m1", 1'b1, i == 4);
    check("m1_conta_pulses", nconta - base, 3);
    step("acerto_hold", FIM_ACERTO);

    start("g2");
    db_modo = 1'b0;
    base = nconta;
    for (int i = 1; i <= 16; i++) jog("m0", 1'b1, i == 16);
    check("m0_conta_pulses", nconta - base, 15);

    start("g3");
    jog("e1", 1'b1, 1'b0);
    jog("e2", 1'b0, 1'b0);
    step("erro_hold", FIM_ERRO);
    start("g4");

    timeout = 1'b1;
    step("timeout", FIM_TIMEOUT);
    timeout = 1'b0;
    step("timeout_hold", FIM_TIMEOUT);
    start("g5");

    timeout = 1'b1;
    jogada_feita = 1'b1;
    step("jog_beats_to", REGISTRA);
    timeout = 1'b0;
    jogada_feita = 1'b0;
    igual = 1'b1;
    step("t6_cmp", COMPARACAO);
    step("t6_prox", PROXIMO);
    igual = 1'b0;
    step("t6_back", ESPERA_JOGADA);

    #2;
    reset = 1'b0;
    q.push_back('{"async_reset", INICIAL});
    ->chk_ev;
    #2;
    @(negedge clock);
    reset = 1'b1;
    step("after_release", INICIAL);
    iniciar = 1'b1;
    step("restart", PREPARACAO);
    iniciar = 1'b0;

    repeat (5) if (q.size() > 0) @(negedge clock);
    if (q.size() != 0) check("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
